// File: rtl/two_port_bus_arbiter.sv
// Round-robin arbiter that gives one of two requesters the shared bus.
// Each ownership is capped at MAX_HOLD cycles, and a waiting requester gets the bus without an idle gap.
module two_port_bus_arbiter #(
  parameter int BUS_WIDTH = 8,
  parameter int MAX_HOLD  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0,
  input  logic                 req1,
  input  logic [BUS_WIDTH-1:0] data0,
  input  logic [BUS_WIDTH-1:0] data1,
  input  logic                 done,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 sel,
  output logic [BUS_WIDTH-1:0] bus_out,
  output logic                 bus_valid
);

  localparam int CW = $clog2(MAX_HOLD);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic          sel_q, sel_d;
  logic [CW-1:0] hold_cnt_q, hold_cnt_d;
  logic          hold_limit;

  assign hold_limit = (hold_cnt_q == CW'(MAX_HOLD - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      sel_q      <= 1'b0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      sel_q      <= sel_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    sel_d      = sel_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      IDLE: begin
        // On a tie, last_q == 1 favours port 0 and last_q == 0 favours port 1.
        if (req0 && (!req1 || last_q)) begin
          state_d    = OWN0;
          last_d     = 1'b0;
          sel_d      = 1'b0;
          hold_cnt_d = '0;
        end else if (req1) begin
          state_d    = OWN1;
          last_d     = 1'b1;
          sel_d      = 1'b1;
          hold_cnt_d = '0;
        end
      end
      OWN0: begin
        if (done || !req0 || hold_limit) begin
          if (req1) begin
            state_d    = OWN1;
            last_d     = 1'b1;
            sel_d      = 1'b1;
            hold_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      OWN1: begin
        if (done || !req1 || hold_limit) begin
          if (req0) begin
            state_d    = OWN0;
            last_d     = 1'b0;
            sel_d      = 1'b0;
            hold_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt0      = (state_q == OWN0);
    gnt1      = (state_q == OWN1);
    bus_valid = (state_q == OWN0) || (state_q == OWN1);
    sel       = sel_q;
    bus_out   = sel_q ? data1 : data0;
  end

endmodule

// File: tb/tb_two_port_bus_arbiter.sv
// Directed scoreboard bench for two_port_bus_arbiter with MAX_HOLD=4.
// Each step drives inputs, queues the expected outputs and checks them after the edge.
module tb_two_port_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset, req0, req1, done;
  logic [7:0] data0, data1, bus_out;
  logic       gnt0, gnt1, sel, bus_valid;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      tag;
    logic       g0;
    logic       g1;
    logic       s;
    logic [7:0] bus;
  } exp_t;

  exp_t sb_q[$];

  two_port_bus_arbiter #(.BUS_WIDTH(8), .MAX_HOLD(4)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1),
    .data0(data0), .data1(data1), .done(done),
    .gnt0(gnt0), .gnt1(gnt1), .sel(sel),
    .bus_out(bus_out), .bus_valid(bus_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic q0, input logic q1,
                      input logic d, input logic eg0, input logic eg1, input logic es);
    exp_t e;
    @(negedge clk);
    reset = r; req0 = q0; req1 = q1; done = d;
    data0 = 8'($urandom); data1 = 8'($urandom);
    e.tag = tag; e.g0 = eg0; e.g1 = eg1; e.s = es;
    e.bus = es ? data1 : data0;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check({e.tag, ".gnt0"}, 32'(gnt0), 32'(e.g0));
    check({e.tag, ".gnt1"}, 32'(gnt1), 32'(e.g1));
    check({e.tag, ".sel"}, 32'(sel), 32'(e.s));
    check({e.tag, ".valid"}, 32'(bus_valid), 32'(e.g0 | e.g1));
    check({e.tag, ".bus"}, 32'(bus_out), 32'(e.bus));
    $display("step %-10s r=%b q0=%b q1=%b d=%b -> g0=%b g1=%b sel=%b v=%b bus=%h",
             e.tag, r, q0, q1, d, gnt0, gnt1, sel, bus_valid, bus_out);
  endtask

  initial begin
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; done = 1'b0;
    data0 = 8'h00; data1 = 8'h00;
    step("rst",     1, 0, 0, 0, 0, 0, 0);
    step("rst_pri", 1, 1, 1, 1, 0, 0, 0);
    step("tie",     0, 1, 1, 0, 1, 0, 0);
    step("handoff", 0, 1, 1, 1, 0, 1, 1);
    step("own1",    0, 0, 1, 0, 0, 1, 1);
    step("mid_rst", 1, 0, 1, 0, 0, 0, 0);
    step("tie2",    0, 1, 1, 0, 1, 0, 0);
    step("drop",    0, 0, 0, 0, 0, 0, 0);
    step("short1",  0, 0, 1, 0, 0, 1, 1);
    step("short1b", 0, 0, 0, 0, 0, 0, 1);
    step("idle_dn", 0, 0, 0, 1, 0, 0, 1);
    for (int i = 0; i < 4; i++) step("force_hi", 0, 1, 0, 0, 1, 0, 0);
    step("force_lo", 0, 1, 0, 0, 0, 0, 0);
    step("regrant", 0, 1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step("starve_w", 0, 1, 1, 0, 1, 0, 0);
    step("starve_g", 0, 1, 1, 0, 0, 1, 1);
    step("back0",   0, 1, 1, 1, 1, 0, 0);
    step("idle2",   0, 0, 0, 0, 0, 0, 0);
    step("rr_tie",  0, 1, 1, 0, 0, 1, 1);
    step("idle3",   0, 0, 0, 0, 0, 0, 1);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
